// File: rtl/traceback_unit_pkg.sv
// Shared definitions for the Viterbi traceback unit: default trellis and
// survivor-memory geometry, FSM state codes and circular-pointer helpers.
package traceback_unit_pkg;

    // Trellis geometry for the K=7 code and survivor-memory sizing.
    localparam int TBU_NUM_STATES = 64;
    localparam int TBU_STATE_W    = 6;
    localparam int TBU_TB_LEN     = 24;
    localparam int TBU_MEM_DEPTH  = 64;

    // Traceback FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_TRACE = 2'b01;
    localparam logic [1:0] ST_OUT   = 2'b10;

    // Step a circular pointer forward; works for non power-of-two depths too.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

    // Step a circular pointer backward; works for non power-of-two depths too.
    function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
        if (ptr == 32'd0) begin
            return depth - 32'd1;
        end else begin
            return ptr - 32'd1;
        end
    endfunction

endpackage

// File: rtl/traceback_unit_survivor_mem.sv
// Survivor decision storage: one row of ACS decisions per trellis step.
// Synchronous write, combinational read, contents untouched by reset.
module survivor_mem
    import traceback_unit_pkg::*;
#(
    parameter int NUM_STATES = TBU_NUM_STATES,
    parameter int MEM_DEPTH  = TBU_MEM_DEPTH,
    parameter int ADDR_W     = $clog2(TBU_MEM_DEPTH)
)(
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [NUM_STATES-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [NUM_STATES-1:0] o_rd_data
);

    logic [NUM_STATES-1:0] r_mem [MEM_DEPTH];

    // Store one decision row per write; no reset so the array maps to RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback unit. Decision rows stream into a circular survivor
// memory; on request the unit walks TB_LEN steps back from the given
// best-metric state and emits the oldest decoded bit plus the state reached.
// Parameter sets must satisfy TB_LEN+2 <= MEM_DEPTH-TB_LEN so that writes
// arriving during a walk never overwrite a row that is still to be read.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int NUM_STATES = TBU_NUM_STATES,
    parameter int STATE_W    = TBU_STATE_W,
    parameter int TB_LEN     = TBU_TB_LEN,
    parameter int MEM_DEPTH  = TBU_MEM_DEPTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [NUM_STATES-1:0] dec_bits,
    input  logic                  start_valid,
    input  logic [STATE_W-1:0]    start_state,
    output logic                  start_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  out_bit,
    output logic [STATE_W-1:0]    out_state,
    output logic                  start_drop
);

    localparam int PTR_W  = $clog2(MEM_DEPTH);
    localparam int FILL_W = $clog2(MEM_DEPTH + 1);
    localparam int STEP_W = $clog2(TB_LEN + 1);

    logic [1:0]            r_state;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FILL_W-1:0]     r_fill_cnt;
    logic [STEP_W-1:0]     r_step_cnt;
    logic [STATE_W-1:0]    r_cur_state;
    logic                  r_out_valid;
    logic                  r_out_bit;
    logic [STATE_W-1:0]    r_out_state;
    logic                  r_start_drop;

    logic [1:0]            w_state_nxt;
    logic                  w_wr_en;
    logic                  w_start_ready;
    logic                  w_accept;
    logic                  w_last_step;
    logic [NUM_STATES-1:0] w_rd_data;
    logic                  w_surv_bit;
    logic [STATE_W-1:0]    w_prev_state;

    assign w_wr_en       = dec_valid & ~rst;
    assign w_start_ready = (r_state == ST_IDLE) && (r_fill_cnt >= FILL_W'(TB_LEN));
    assign w_accept      = start_valid & w_start_ready;
    assign w_last_step   = (r_step_cnt == STEP_W'(TB_LEN - 1));

    // The survivor bit of the current state names the predecessor's LSB.
    assign w_surv_bit    = w_rd_data[r_cur_state];
    assign w_prev_state  = {r_cur_state[STATE_W-2:0], w_surv_bit};

    survivor_mem #(
        .NUM_STATES (NUM_STATES),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_survivor_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (dec_bits),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Write pointer and fill level follow every decision row; writes never stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else if (dec_valid) begin
            r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), MEM_DEPTH));
            if (r_fill_cnt != FILL_W'(MEM_DEPTH)) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end else begin
                r_fill_cnt <= r_fill_cnt;
            end
        end else begin
            r_wr_ptr   <= r_wr_ptr;
            r_fill_cnt <= r_fill_cnt;
        end
    end

    // Next-state selection for the IDLE -> TRACE -> OUT -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_TRACE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRACE: begin
                if (w_last_step) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_TRACE;
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state plus the walk-back registers (current state, read pointer, step count).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd_ptr    <= '0;
            r_step_cnt  <= '0;
            r_cur_state <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Newest row already in memory; a same-cycle write is not part of this walk.
                        r_cur_state <= start_state;
                        r_rd_ptr    <= PTR_W'(ptr_dec(32'(r_wr_ptr), MEM_DEPTH));
                        r_step_cnt  <= '0;
                    end
                end
                ST_TRACE: begin
                    r_cur_state <= w_prev_state;
                    r_rd_ptr    <= PTR_W'(ptr_dec(32'(r_rd_ptr), MEM_DEPTH));
                    r_step_cnt  <= r_step_cnt + STEP_W'(1);
                end
                default: begin
                    r_cur_state <= r_cur_state;
                end
            endcase
        end
    end

    // Registered result strobe, held result and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_out_state  <= '0;
            r_start_drop <= 1'b0;
        end else begin
            r_out_valid  <= (r_state == ST_TRACE) && w_last_step;
            r_start_drop <= start_valid & ~w_start_ready;
            if ((r_state == ST_TRACE) && w_last_step) begin
                // Capture the state the final step lands on so it is valid during OUT.
                r_out_bit   <= w_prev_state[STATE_W-1];
                r_out_state <= w_prev_state;
            end else begin
                r_out_bit   <= r_out_bit;
                r_out_state <= r_out_state;
            end
        end
    end

    assign start_ready = w_start_ready;
    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = r_out_valid;
    assign out_bit     = r_out_bit;
    assign out_state   = r_out_state;
    assign start_drop  = r_start_drop;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: random decision rows and encoder-shaped paths,
// compared against a behavioural survivor-memory/traceback model.
module tb_traceback_unit;

    localparam int NS  = 64;
    localparam int SW  = 6;
    localparam int TBL = 24;
    localparam int MD  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic [NS-1:0] dec_bits;
    logic          start_valid;
    logic [SW-1:0] start_state;
    logic          start_ready;
    logic          busy;
    logic          out_valid;
    logic          out_bit;
    logic [SW-1:0] out_state;
    logic          start_drop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int out_cnt  = 0;

    // Behavioural model of the survivor memory
    logic [NS-1:0] m_mem [MD];
    int            m_wr;
    int            m_fill;

    // Encoder path generator
    logic [SW-1:0] enc_s;
    int            enc_t;
    logic [SW-1:0] state_hist [512];

    // Last observed result
    logic          obs_bit;
    logic [SW-1:0] obs_state;

    traceback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_bits    (dec_bits),
        .start_valid (start_valid),
        .start_state (start_state),
        .start_ready (start_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_state   (out_state),
        .start_drop  (start_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) out_cnt <= out_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; mirror the write into the model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_wr   = 0;
            m_fill = 0;
        end else if (dec_valid) begin
            m_mem[m_wr] = dec_bits;
            m_wr        = (m_wr + 1) % MD;
            if (m_fill < MD) m_fill++;
        end
    endtask

    // Walk back TBL steps: predecessor of s is (2s + decision) mod 64.
    function automatic logic [SW-1:0] model_tb(input logic [SW-1:0] st);
        int rd;
        int s;
        s  = st;
        rd = (m_wr + MD - 1) % MD;
        for (int i = 0; i < TBL; i++) begin
            s  = (s * 2 + int'(m_mem[rd][s])) % NS;
            rd = (rd + MD - 1) % MD;
        end
        return SW'(s);
    endfunction

    task automatic do_reset();
        rst = 1'b1; dec_valid = 1'b0; start_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [NS-1:0] d);
        dec_valid = 1'b1;
        dec_bits  = d;
        tick();
        dec_valid = 1'b0;
    endtask

    // One encoder step: next state shifts the input bit in at the MSB; the
    // new state's decision names the old state's LSB, other bits are noise.
    task automatic enc_write();
        logic [SW-1:0] prev;
        logic [NS-1:0] d;
        prev  = enc_s;
        enc_s = {1'($urandom_range(0, 1)), prev[SW-1:1]};
        d     = {$urandom, $urandom};
        d[enc_s] = prev[0];
        enc_t++;
        state_hist[enc_t] = enc_s;
        write_word(d);
    endtask

    task automatic enc_init();
        enc_s = '0;
        enc_t = 0;
        state_hist[0] = '0;
    endtask

    // Issue an accepted start and check the single result against exp_state.
    task automatic trace_and_check(input string tag, input logic [SW-1:0] st,
                                   input bit stream, input logic [SW-1:0] exp_state);
        int  acc;
        bit  seen;
        int  base;
        base = out_cnt;
        check({tag, "_ready"}, start_ready, 1'b1);
        start_valid = 1'b1;
        start_state = st;
        if (stream) enc_write(); else tick();
        start_valid = 1'b0;
        acc = cyc;
        check({tag, "_busy"}, busy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (stream) enc_write(); else tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, seen, 1'b1);
        if (seen) begin
            obs_bit   = out_bit;
            obs_state = out_state;
            check({tag, "_latency"}, cyc - acc, TBL);
            check({tag, "_state"}, out_state, exp_state);
            check({tag, "_bit"}, out_bit, exp_state[SW-1]);
        end
        tick();
        tick();
        check({tag, "_hold"}, out_state, exp_state);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_one_pulse"}, out_cnt - base, 1);
    endtask

    initial begin
        logic [SW-1:0] exp_s;
        logic [SW-1:0] st;
        int            base;
        int            t0;

        rst = 1'b1; dec_valid = 1'b0; dec_bits = '0; start_valid = 1'b0; start_state = '0;
        m_wr = 0; m_fill = 0;
        enc_init();

        // Reset state
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_ready", start_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_bit", out_bit, 1'b0);
        check("rst_out_state", out_state, 6'h00);
        check("rst_drop", start_drop, 1'b0);

        // Too few rows: request dropped; the 24th row enables acceptance
        for (int i = 0; i < 23; i++) write_word({$urandom, $urandom});
        check("fill23_ready", start_ready, 1'b0);
        base = out_cnt;
        start_valid = 1'b1; start_state = 6'($urandom);
        tick();
        start_valid = 1'b0;
        check("fill23_drop", start_drop, 1'b1);
        check("fill23_busy", busy, 1'b0);
        tick();
        check("fill23_drop_clear", start_drop, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        check("fill23_no_out", out_cnt - base, 0);
        write_word({$urandom, $urandom});
        check("fill24_ready", start_ready, (m_fill >= TBL) ? 1'b1 : 1'b0);
        st = 6'($urandom);
        trace_and_check("fill24", st, 1'b0, model_tb(st));

        // All-zero decisions from state 3F
        do_reset();
        for (int i = 0; i < 30; i++) write_word('0);
        trace_and_check("zeros", 6'h3F, 1'b0, model_tb(6'h3F));
        check("zeros_const_state", obs_state, 6'h00);
        check("zeros_const_bit", obs_bit, 1'b0);

        // All-one decisions from state 00
        do_reset();
        for (int i = 0; i < 30; i++) write_word('1);
        trace_and_check("ones", 6'h00, 1'b0, model_tb(6'h00));
        check("ones_const_state", obs_state, 6'h3F);
        check("ones_const_bit", obs_bit, 1'b1);

        // Second request while busy is dropped, only one result
        for (int i = 0; i < 8; i++) write_word({$urandom, $urandom});
        st = 6'($urandom);
        exp_s = model_tb(st);
        base = out_cnt;
        start_valid = 1'b1; start_state = st;
        tick();
        start_valid = 1'b0;
        tick(); tick();
        check("busy_ready_low", start_ready, 1'b0);
        start_valid = 1'b1; start_state = ~st;
        tick();
        start_valid = 1'b0;
        check("busy_drop", start_drop, 1'b1);
        t0 = 0;
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin tick(); t0++; end
        check("busy_out_state", out_state, exp_s);
        for (int i = 0; i < 40; i++) tick();
        check("busy_single_out", out_cnt - base, 1);

        // Encoder-shaped path across pointer wrap, with writes streaming during traceback
        do_reset();
        enc_init();
        for (int i = 0; i < 130; i++) enc_write();
        for (int k = 0; k < 4; k++) begin
            int t_acc;
            t_acc = enc_t;
            st = (k % 2 == 0) ? enc_s : 6'($urandom);
            trace_and_check("enc", st, 1'b1, model_tb(st));
            if (k % 2 == 0) begin
                check("enc_path_state", obs_state, state_hist[t_acc - TBL]);
                check("enc_path_bit", obs_bit, state_hist[t_acc - TBL][SW-1]);
            end
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) enc_write();
        end

        // Reset in the middle of a traceback
        do_reset();
        for (int i = 0; i < 30; i++) write_word({$urandom, $urandom});
        base = out_cnt;
        start_valid = 1'b1; start_state = 6'($urandom);
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", start_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_out", out_cnt - base, 0);
        for (int i = 0; i < 23; i++) write_word({$urandom, $urandom});
        check("abort_fill23_ready", start_ready, 1'b0);
        write_word({$urandom, $urandom});
        check("abort_fill24_ready", start_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
